// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int unsigned XFER_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester search: first set req bit at or above rr_ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_rr_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_valid
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_pick  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_idx = PW'((32'(i_rr_ptr) + i) % N_REQ);
      if (!w_found && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ requesters.
`ifndef DATA
`define DATA 8
`endif

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned DW        = `DATA
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      ack,
  output logic                  winc,
  output logic [DW-1:0]         wdata,
  input  logic                  wfull,
  output logic                  busy,
  output logic [XFER_CNT_W-1:0] xfer_cnt
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e                r_state;
  logic [PW-1:0]         r_owner;
  logic [PW-1:0]         r_rr_ptr;
  logic [7:0]            r_burst_cnt;
  logic [XFER_CNT_W-1:0] r_xfer_cnt;

  logic [N_REQ-1:0] w_pick;
  logic             w_pick_valid;
  logic [PW-1:0]    w_pick_idx;
  logic [N_REQ-1:0] w_gnt;
  logic             w_req_own;
  logic [DW-1:0]    w_wdata;
  logic             w_winc;
  logic             w_last;
  logic [PW-1:0]    w_rr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_pick   (w_pick),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick[i]) w_pick_idx = PW'(i);
    end
  end

  // Owner decode; everything stays zero while idle.
  always_comb begin
    w_gnt     = '0;
    w_req_own = 1'b0;
    w_wdata   = '0;
    if (r_state == BURST) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (PW'(i) == r_owner) begin
          w_gnt[i]  = 1'b1;
          w_req_own = req[i];
          w_wdata   = req_data[i*DW +: DW];
        end
      end
    end
  end

  assign w_winc    = w_req_own && !wfull;
  assign w_last    = w_winc && (r_burst_cnt == 8'(MAX_BURST - 1));
  assign w_rr_next = (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_xfer_cnt  <= '0;
    end else begin
      if (w_winc && (r_xfer_cnt != '1)) r_xfer_cnt <= r_xfer_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (!w_req_own || w_last) begin
            r_state     <= IDLE;
            r_rr_ptr    <= w_rr_next;
            r_burst_cnt <= '0;
          end else if (w_winc) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt      = w_gnt;
  assign ack      = {N_REQ{w_winc}} & w_gnt;
  assign winc     = w_winc;
  assign wdata    = w_wdata;
  assign busy     = (r_state == BURST);
  assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 requesters, burst 8) plus a
// second 2-requester instance run long enough to reach xfer_cnt saturation.
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        wrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        winc;
  logic [7:0]  wdata;
  logic        wfull;
  logic        busy;
  logic [15:0] xfer_cnt;

  logic        rst2;
  logic [1:0]  req2;
  logic [15:0] req_data2;
  logic [1:0]  gnt2;
  logic [1:0]  ack2;
  logic        winc2;
  logic [7:0]  wdata2;
  logic        busy2;
  logic [15:0] xfer_cnt2;

  int n_checks = 0;
  int n_fail   = 0;
  int m2       = 0;

  fifo_wr_arbiter #(
    .N_REQ     (4),
    .MAX_BURST (8),
    .DW        (8)
  ) dut (
    .wclk     (wclk),
    .wrst     (wrst),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ack      (ack),
    .winc     (winc),
    .wdata    (wdata),
    .wfull    (wfull),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  fifo_wr_arbiter #(
    .N_REQ     (2),
    .MAX_BURST (255),
    .DW        (8)
  ) dut_sat (
    .wclk     (wclk),
    .wrst     (rst2),
    .req      (req2),
    .req_data (req_data2),
    .gnt      (gnt2),
    .ack      (ack2),
    .winc     (winc2),
    .wdata    (wdata2),
    .wfull    (1'b0),
    .busy     (busy2),
    .xfer_cnt (xfer_cnt2)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Unsaturated count of words written by the long-running instance.
  always @(posedge wclk) begin
    if (rst2) m2 <= 0;
    else if (winc2) m2 <= m2 + 1;
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst  = 1'b1;
    req   = 4'b0000;
    wfull = 1'b0;
    tick();
    tick();
    wrst = 1'b0;
  endtask

  // Slice i carries {i, k} so the bench knows which requester wdata came from.
  task automatic set_data(input int k);
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'((i << 4) | (k & 15));
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_checks++; if (winc !== 1'b0) begin n_fail++; $display("FAIL reset_winc got %b want 0", winc); end
    n_checks++; if (xfer_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_xfer got %h want 0000", xfer_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    set_data(5);
    req = 4'b0001;
    #1;
    n_checks++; if (gnt !== 4'b0000 || winc !== 1'b0) begin
      n_fail++; $display("FAIL single_bubble gnt=%b winc=%b want 0000/0", gnt, winc); end
    tick();
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++; if (gnt !== 4'b0001 || winc !== 1'b1 || ack !== 4'b0001) begin
        n_fail++; $display("FAIL single_word%0d gnt=%b winc=%b ack=%b want 0001/1/0001", k, gnt, winc, ack); end
      n_checks++; if (wdata !== 8'h05) begin
        n_fail++; $display("FAIL single_wdata%0d got %h want 05", k, wdata); end
      tick();
    end
    #1;
    n_checks++; if (gnt !== 4'b0000 || winc !== 1'b0 || wdata !== 8'h00) begin
      n_fail++; $display("FAIL single_idle gnt=%b winc=%b wdata=%h want 0000/0/00", gnt, winc, wdata); end
    n_checks++; if (xfer_cnt !== 16'd8) begin
      n_fail++; $display("FAIL single_xfer got %0d want 8", xfer_cnt); end
    tick();
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_regrant got %b want 0001", gnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      #1;
      n_checks++; if (gnt !== 4'b0000 || ack !== 4'b0000) begin
        n_fail++; $display("FAIL rr_bubble%0d gnt=%b ack=%b want 0000/0000", o, gnt, ack); end
      tick();
      for (int k = 0; k < 8; k++) begin
        set_data(k + o);
        exp_g = 4'b0001 << (o % 4);
        exp_d = 8'(((o % 4) << 4) | ((k + o) & 15));
        #1;
        n_checks++; if (gnt !== exp_g || ack !== exp_g || winc !== 1'b1) begin
          n_fail++; $display("FAIL rr_grant o%0d k%0d gnt=%b ack=%b winc=%b want %b", o, k, gnt, ack, winc, exp_g); end
        n_checks++; if (wdata !== exp_d) begin
          n_fail++; $display("FAIL rr_wdata o%0d k%0d got %h want %h", o, k, wdata, exp_d); end
        tick();
      end
    end
    #1;
    n_checks++; if (xfer_cnt !== 16'd40) begin n_fail++; $display("FAIL rr_xfer got %0d want 40", xfer_cnt); end
  endtask

  task automatic test_wfull_stall();
    do_reset();
    set_data(9);
    req = 4'b0100;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (winc !== 1'b1 || gnt !== 4'b0100) begin
        n_fail++; $display("FAIL stall_pre%0d winc=%b gnt=%b want 1/0100", k, winc, gnt); end
      tick();
    end
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (winc !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0100) begin
        n_fail++; $display("FAIL stall_full%0d winc=%b ack=%b gnt=%b want 0/0000/0100", k, winc, ack, gnt); end
      tick();
    end
    wfull = 1'b0;
    req   = 4'b1100;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (winc !== 1'b1 || gnt !== 4'b0100 || wdata !== 8'h29) begin
        n_fail++; $display("FAIL stall_post%0d winc=%b gnt=%b wdata=%h want 1/0100/29", k, winc, gnt, wdata); end
      tick();
    end
    #1;
    n_checks++; if (gnt !== 4'b0000 || xfer_cnt !== 16'd8) begin
      n_fail++; $display("FAIL stall_exit gnt=%b xfer=%0d want 0000/8", gnt, xfer_cnt); end
    tick();
    #1;
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL stall_rotate got %b want 1000", gnt); end
  endtask

  task automatic test_drop();
    do_reset();
    set_data(3);
    req = 4'b0010;
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (winc !== 1'b1 || gnt !== 4'b0010) begin
        n_fail++; $display("FAIL drop_word%0d winc=%b gnt=%b want 1/0010", k, winc, gnt); end
      tick();
    end
    req = 4'b1001;
    #1;
    n_checks++; if (winc !== 1'b0 || ack !== 4'b0000) begin
      n_fail++; $display("FAIL drop_noack winc=%b ack=%b want 0/0000", winc, ack); end
    tick();
    #1;
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle gnt=%b busy=%b want 0000/0", gnt, busy); end
    tick();
    #1;
    n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_next got %b want 1000", gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_data(1);
    req = 4'b1000;
    tick();
    tick();
    tick();
    wrst = 1'b1;
    tick();
    wrst = 1'b0;
    req  = 4'b1111;
    #1;
    n_checks++; if (gnt !== 4'b0000 || winc !== 1'b0 || ack !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_out gnt=%b winc=%b ack=%b want 0000/0/0000", gnt, winc, ack); end
    n_checks++; if (xfer_cnt !== 16'h0) begin n_fail++; $display("FAIL rstmid_xfer got %h want 0000", xfer_cnt); end
    tick();
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_next got %b want 0001", gnt); end
  endtask

  task automatic test_saturate();
    logic [15:0] exp_c;
    int          budget;
    budget = 0;
    while (m2 <= 65540 && budget < 70000) begin
      tick();
      budget++;
      if (m2 >= 65533 && m2 <= 65540) begin
        exp_c = (m2 > 65535) ? 16'hFFFF : 16'(m2);
        n_checks++; if (xfer_cnt2 !== exp_c) begin
          n_fail++; $display("FAIL saturate m=%0d got %h want %h", m2, xfer_cnt2, exp_c); end
      end
    end
    n_checks++; if (budget >= 70000) begin
      n_fail++; $display("FAIL saturate_timeout writes=%0d want >65540", m2); end
  endtask

  initial begin
    wrst      = 1'b1;
    req       = 4'b0000;
    req_data  = '0;
    wfull     = 1'b0;
    rst2      = 1'b1;
    req2      = 2'b00;
    req_data2 = 16'hA55A;
    test_reset();
    rst2 = 1'b0;
    req2 = 2'b11;
    test_single();
    test_round_robin();
    test_wfull_stall();
    test_drop();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
